// File: rtl/blast_sequencer_pkg.sv
// Shared constants for the blast sequencer: tile codes, grid defaults, directions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package blast_sequencer_pkg;

  // Default playfield and slot count
  localparam int GRID_W_DEF  = 11;
  localparam int GRID_H_DEF  = 11;
  localparam int N_BOMBS_DEF = 6;

  // Tile codes held in the stage RAM; anything >= TILE_PWR_MIN is a revealed powerup
  localparam logic [3:0] TILE_EMPTY   = 4'd0;
  localparam logic [3:0] TILE_WALL    = 4'd1;
  localparam logic [3:0] TILE_SOFT    = 4'd2;
  localparam logic [3:0] TILE_PWR_MIN = 4'd3;

  // Ray directions, walked in ascending order
  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_PY = 2'd1;
  localparam logic [1:0] DIR_NX = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Radius code to reach in tiles; code 3 saturates at the same reach as code 2
  function automatic logic [1:0] reach_of(input logic [1:0] code);
    return (code == 2'd3) ? 2'd3 : code + 2'd1;
  endfunction

endpackage

// File: rtl/blast_sequencer_rr_arbiter.sv
// Round-robin grant over N requesters; pointer advances past the winner on upd_i.
// Latency: grant is combinational from req_i; pointer updates on the next clock.
// Backpressure: none; requests are levels and simply stay pending until granted.
module rr_arbiter #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [N-1:0]     req_i,
  output logic             gnt_vld_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // (base + off) mod N, valid for base < N and off < N
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Scan from the pointer upward; walking backwards lets the closest request win
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[wrap_add(ptr_q, i)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = wrap_add(ptr_q, i);
      end
    end
  end

  // Clear wins over update so a stage reload always restarts fairness at slot 0
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (upd_i) begin
      ptr_d = wrap_add(gnt_idx_o, 1);
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/blast_sequencer.sv
// Resolves one bomb blast at a time: walks four rays through the tile RAM, clearing blocks.
// Latency: det_ack 2 + 2*(tiles read) + (directions skipped) cycles after the grant cycle.
// Backpressure: det_req levels are held by the requester until det_ack; RAM never stalls.
module blast_sequencer
  import blast_sequencer_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int N_BOMBS = N_BOMBS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stage_clear,
  input  logic [N_BOMBS-1:0] det_req,
  output logic [N_BOMBS-1:0] det_ack,
  output logic [2:0]         bomb_sel,
  input  logic [3:0]         bomb_tx,
  input  logic [3:0]         bomb_ty,
  input  logic [1:0]         bomb_radius,
  output logic [6:0]         ram_addr,
  output logic               ram_rd,
  input  logic [3:0]         ram_rdata,
  input  logic [3:0]         init_rdata,
  output logic               ram_we,
  output logic [3:0]         ram_wdata,
  output logic               busy
);

  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
  localparam logic [6:0] ROW_W = 7'(GRID_W);

  logic [2:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
  logic [1:0] reach_q, reach_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] dist_q, dist_d;
  logic [6:0] addr_q, addr_d;

  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic       ptr_upd;
  logic       next_dir;

  logic [4:0] tgt_x, tgt_y;
  logic       tgt_ok;
  logic [6:0] tgt_addr;

  // A grant only counts when the stage is not being reloaded in the same cycle
  assign ptr_upd  = (state_q == ST_IDLE) && gnt_vld && !stage_clear;
  assign busy     = (state_q != ST_IDLE);
  assign bomb_sel = sel_q;

  rr_arbiter #(
    .N     (N_BOMBS),
    .IDX_W (3)
  ) u_rr_arbiter (
    .clk_i     (clk),
    .rst_i     (reset),
    .clr_i     (stage_clear),
    .upd_i     (ptr_upd),
    .req_i     (det_req),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  // Target tile for the current ray step; underflow on -X/-Y is caught before the bound check
  always_comb begin
    tgt_x  = {1'b0, cx_q};
    tgt_y  = {1'b0, cy_q};
    tgt_ok = 1'b1;
    case (dir_q)
      DIR_PX: tgt_x = {1'b0, cx_q} + {3'b0, dist_q};
      DIR_PY: tgt_y = {1'b0, cy_q} + {3'b0, dist_q};
      DIR_NX: begin
        tgt_ok = ({2'b0, dist_q} <= cx_q);
        tgt_x  = {1'b0, cx_q} - {3'b0, dist_q};
      end
      default: begin
        tgt_ok = ({2'b0, dist_q} <= cy_q);
        tgt_y  = {1'b0, cy_q} - {3'b0, dist_q};
      end
    endcase
    tgt_ok   = tgt_ok && (tgt_x <= X_MAX) && (tgt_y <= Y_MAX);
    tgt_addr = ({2'b0, tgt_y} * ROW_W) + {2'b0, tgt_x};
  end

  // Sequencer next state and RAM/ack strobes; stage_clear overrides everything last
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    reach_d   = reach_q;
    dir_d     = dir_q;
    dist_d    = dist_q;
    addr_d    = addr_q;
    next_dir  = 1'b0;
    ram_addr  = addr_q;
    ram_rd    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = TILE_EMPTY;
    det_ack   = '0;
    case (state_q)
      ST_IDLE: begin
        if (ptr_upd) begin
          sel_d   = gnt_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cx_d    = bomb_tx;
        cy_d    = bomb_ty;
        reach_d = reach_of(bomb_radius);
        dir_d   = DIR_PX;
        dist_d  = 2'd1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (tgt_ok) begin
          ram_addr = tgt_addr;
          ram_rd   = 1'b1;
          addr_d   = tgt_addr;
          state_d  = ST_EVAL;
        end else begin
          next_dir = 1'b1;
        end
      end
      ST_EVAL: begin
        if (ram_rdata == TILE_EMPTY) begin
          if (dist_q < reach_q) begin
            dist_d  = dist_q + 2'd1;
            state_d = ST_ISSUE;
          end else begin
            next_dir = 1'b1;
          end
        end else begin
          next_dir = 1'b1;
          if (ram_rdata != TILE_WALL) begin
            // A soft block hiding a powerup reveals it; everything else is burnt to empty
            ram_we = 1'b1;
            if ((ram_rdata == TILE_SOFT) && (init_rdata >= TILE_PWR_MIN)) begin
              ram_wdata = init_rdata;
            end
          end
        end
      end
      ST_DONE: begin
        det_ack = N_BOMBS'(1) << sel_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (next_dir) begin
      if (dir_q == DIR_NY) begin
        state_d = ST_DONE;
      end else begin
        dir_d   = dir_q + 2'd1;
        dist_d  = 2'd1;
        state_d = ST_ISSUE;
      end
    end
    if (stage_clear) begin
      state_d   = ST_IDLE;
      ram_rd    = 1'b0;
      ram_we    = 1'b0;
      ram_wdata = TILE_EMPTY;
      det_ack   = '0;
    end
  end

  // State registers; async reset makes the combinational RAM strobes drop at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      reach_q <= '0;
      dir_q   <= DIR_PX;
      dist_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      reach_q <= reach_d;
      dir_q   <= dir_d;
      dist_q  <= dist_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: doc/blast_sequencer.md
BLAST_SEQUENCER -- requirements
Module: blast_sequencer

Interface
REQ-001 SHALL have parameters: GRID_W, default 11, grid width in tiles; GRID_H, default 11, grid height in tiles; N_BOMBS, default 6, number of bomb slots.
REQ-002 SHALL have port: clk  in  1  system clock (50 MHz); all logic on posedge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: stage_clear  in  1  synchronous abort; stage is being reloaded.
REQ-005 SHALL have port: det_req  in  N_BOMBS  per-slot detonation request; level, held until det_ack.
REQ-006 SHALL have port: det_ack  out  N_BOMBS  one-cycle pulse when the slot's blast is fully resolved.
REQ-007 SHALL have port: bomb_sel  out  3  slot index being serviced.
REQ-008 SHALL have ports: bomb_tx / bomb_ty  in  4 each  tile coordinates of the selected slot, combinational from bomb_sel.
REQ-009 SHALL have port: bomb_radius  in  2  radius code of the selected slot; reach = code+1 tiles, code 3 treated as 2.
REQ-010 SHALL have ports: ram_addr  out  7; ram_rd  out  1; ram_rdata  in  4, valid the cycle after ram_rd.
REQ-011 SHALL have ports: init_rdata  in  4, initial-stage tile at ram_addr with the same 1-cycle latency; ram_we  out  1; ram_wdata  out  4.
REQ-012 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, LOAD, ISSUE, EVAL, DONE.
REQ-014 IDLE: if any det_req is set, SHALL grant one slot round-robin, register bomb_sel and go to LOAD; otherwise stay in IDLE.
REQ-015 Round-robin: the priority pointer SHALL start at 0 and become (granted+1) mod N_BOMBS after each grant.
REQ-016 LOAD: SHALL latch bomb_tx, bomb_ty and reach, set direction=+X and distance=1, then go to ISSUE.
REQ-017 Direction order SHALL be +X, +Y, -X, -Y.
REQ-018 ISSUE: target = centre offset by distance in the current direction.
  - Out of grid (x>GRID_W-1, y>GRID_H-1, or negative): SHALL skip to the next direction in 1 cycle with no read.
  - In grid: SHALL drive ram_addr = ty*GRID_W+tx and ram_rd=1 for 1 cycle, then go to EVAL.
REQ-019 EVAL SHALL act on ram_rdata:
  - 0: no write; continue.
  - 1 (hard wall): no write; end direction.
  - 2 (soft block): write init_rdata if init_rdata>2, else write 0; end direction.
  - >=3 (revealed powerup): write 0; end direction.
  Writes SHALL use ram_we=1 for this 1 cycle, at the same ram_addr.
REQ-020 Continue SHALL mean: distance+1 if distance<reach, else next direction. After -Y ends, SHALL go to DONE.
REQ-021 DONE SHALL pulse det_ack[bomb_sel] for 1 cycle, then go to IDLE.
REQ-022 A det_req bit still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-023 Latency: det_ack SHALL assert exactly 2 + 2*(tiles read) + (directions skipped) cycles after the IDLE grant cycle.
REQ-024 At most one of ram_rd and ram_we SHALL be high in any cycle; both SHALL be 0 outside ISSUE/EVAL.
REQ-025 Address arithmetic SHALL be 7-bit unsigned; the result SHALL never exceed GRID_W*GRID_H-1.
REQ-026 stage_clear, from any state, SHALL force IDLE next cycle with no write and no det_ack in that cycle, and reset the pointer to 0; it has priority over grant.

Reset
REQ-027 On reset SHALL set: state=IDLE, pointer=0, bomb_sel=0, det_ack=0, ram_rd=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0.
REQ-028 Reset asserted mid-blast SHALL drop ram_we and ram_rd immediately (asynchronous); the interrupted blast is discarded.

Structure
REQ-029 The shared package SHALL hold: tile codes (EMPTY=0, WALL=1, SOFT=2, powerup >=3), GRID_W/GRID_H defaults, direction encoding, and the state enum.
REQ-030 SHALL instantiate exactly one sub-module, rr_arbiter, an N-input round-robin grant with a pointer-update strobe.

Verification
REQ-031 Slot 0 at (5,5), radius 0, all tiles 0 -> reads at addrs 61, 71, 59, 49 in that order; no writes; det_ack[0] 10 cycles after grant.
REQ-032 Slot 1 at (0,0), radius 2; (1,0)=2 with init 4; (0,1)=1 -> write 4 at addr 1; no access to addr 22; -X and -Y skipped; ack after 2+4+2=8 cycles.
REQ-033 Slot 2 at (10,10), radius 1; (9,10)=3; (10,9)=0; (10,8)=2 with init 2 -> writes 0 at addr 119 and 0 at addr 98; +X/+Y skipped.
REQ-034 det_req=6'b100001 from reset -> slot 0 serviced first, then slot 5; then det_req=6'b000011 -> slot 0 before slot 1.
REQ-035 stage_clear during EVAL of a soft block -> no ram_we in that cycle; busy=0 next cycle; no det_ack.
REQ-036 reset asserted mid-cycle while ram_we=1 -> ram_we=0 before the next clock edge; all outputs at reset values.
